// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: walks active-low rows, synchronizes the columns, debounces
// press and release on the latched column, and reports one code per physical press.
module key_matrix_scan #(
    parameter int ROW_DWELL = 4,
    parameter int DEB_CNT   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] kcol,
    output logic [3:0] krow,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int DW_W  = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
    localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(ROW_DWELL - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CNT - 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_csync1, r_csync2;
    logic [1:0]       r_row, w_row_nxt;
    logic [1:0]       r_col, w_col_nxt;
    logic [DW_W-1:0]  r_dwell, w_dwell_nxt;
    logic [DEB_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_code, w_code_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_down, w_down_nxt;
    logic             w_col_hi;
    logic [1:0]       w_low_col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csync1 <= 4'b1111;
            r_csync2 <= 4'b1111;
            r_state  <= S_SCAN;
            r_row    <= 2'd0;
            r_col    <= 2'd0;
            r_dwell  <= '0;
            r_cnt    <= '0;
            r_code   <= 4'd0;
            r_valid  <= 1'b0;
            r_down   <= 1'b0;
        end else begin
            r_csync1 <= kcol;
            r_csync2 <= r_csync1;
            r_state  <= w_state_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_dwell  <= w_dwell_nxt;
            r_cnt    <= w_cnt_nxt;
            r_code   <= w_code_nxt;
            r_valid  <= w_valid_nxt;
            r_down   <= w_down_nxt;
        end
    end

    assign w_col_hi = r_csync2[r_col];

    // Column 0 wins when several keys in the driven row are down.
    always_comb begin
        w_low_col = 2'd3;
        if (!r_csync2[0])      w_low_col = 2'd0;
        else if (!r_csync2[1]) w_low_col = 2'd1;
        else if (!r_csync2[2]) w_low_col = 2'd2;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        w_down_nxt  = r_down;
        case (r_state)
            S_SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    if (r_csync2 == 4'b1111) begin
                        w_row_nxt   = r_row + 2'd1;
                        w_dwell_nxt = '0;
                    end else begin
                        w_col_nxt   = w_low_col;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DEBOUNCE;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (w_col_hi) begin
                    w_state_nxt = S_SCAN;
                    w_row_nxt   = r_row + 2'd1;
                    w_dwell_nxt = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = S_PRESSED;
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = {r_row, r_col};
                    w_down_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PRESSED: begin
                if (w_col_hi) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE: begin
                // A low sample restarts the release window instead of re-reporting the key.
                if (!w_col_hi) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_down_nxt  = 1'b0;
                    w_state_nxt = S_SCAN;
                    w_row_nxt   = r_row + 2'd1;
                    w_dwell_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_SCAN;
        endcase
    end

    assign krow      = ~(4'b0001 << r_row);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_down  = r_down;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: keypad model drives kcol from krow; a cycle model of the
// scanner's rules is compared against the outputs every cycle, plus literal spot checks.
module tb_key_matrix_scan;
    localparam int DW  = 4;
    localparam int DEB = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  kcol, krow, key_code;
    logic        key_valid, key_down;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  kcol_ne;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;

    key_matrix_scan #(.ROW_DWELL(DW), .DEB_CNT(DEB)) dut (
        .clk(clk), .rst(rst), .kcol(kcol), .krow(krow),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // Keypad: key (r,c) pulls column c low while its row r is driven low.
    always_comb begin
        kcol = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !krow[r]) kcol[c] = 1'b0;
    end

    always @(negedge clk) kcol_ne <= kcol;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scanner model: phase 0 scan, 1 press debounce, 2 held, 3 release debounce.
    int         m_phase, m_scan_t, m_base_row, m_run, m_row, m_col;
    logic [3:0] m_s1, m_s2, m_code;
    logic       m_valid, m_down;

    function automatic int cur_row();
        if (m_phase == 0) return (m_base_row + m_scan_t / DW) % 4;
        return m_row;
    endfunction

    task model_reset();
        m_phase = 0; m_scan_t = 0; m_base_row = 0; m_run = 0; m_row = 0; m_col = 0;
        m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0; m_valid = 1'b0; m_down = 1'b0;
    endtask

    task restart_scan();
        m_base_row = (m_row + 1) % 4;
        m_scan_t   = 0;
        m_phase    = 0;
    endtask

    task model_step(input logic [3:0] kin);
        logic [3:0] s;
        s = m_s2; m_s2 = m_s1; m_s1 = kin;
        m_valid = 1'b0;
        case (m_phase)
            0: begin
                if ((m_scan_t % DW) == DW - 1 && s != 4'hF) begin
                    m_row = cur_row();
                    for (int c = 3; c >= 0; c--) if (!s[c]) m_col = c;
                    m_phase = 1;
                    m_run = 0;
                end else begin
                    m_scan_t++;
                end
            end
            1: begin
                if (s[m_col]) restart_scan();
                else begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_phase = 2; m_valid = 1'b1; m_down = 1'b1;
                        m_code = 4'(m_row * 4 + m_col);
                    end
                end
            end
            2: if (s[m_col]) begin m_phase = 3; m_run = 0; end
            default: begin
                if (s[m_col]) begin
                    m_run++;
                    if (m_run == DEB) begin m_down = 1'b0; restart_scan(); end
                end else m_run = 0;
            end
        endcase
    endtask

    always @(posedge clk) begin
        logic [3:0] ek;
        #1;
        if (rst) model_reset();
        else     model_step(kcol_ne);
        ek = 4'b1111;
        ek[cur_row()] = 1'b0;
        chk("krow",      32'(krow),      32'(ek));
        chk("key_code",  32'(key_code),  32'(m_code));
        chk("key_valid", 32'(key_valid), 32'(m_valid));
        chk("key_down",  32'(key_down),  32'(m_down));
        if (key_valid === 1'b1) vcount++;
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [15:0] kduring);
        @(posedge clk); #3;
        rst  = 1'b1;
        keys = kduring;
        #1;
        chk("rst_krow",  32'(krow),      32'h0000000E);
        chk("rst_code",  32'(key_code),  32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_down",  32'(key_down),  32'h0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
    endtask

    logic [3:0] seq [4];
    int v0, n;
    bit seen;

    initial begin
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;

        // Idle scan
        do_reset(16'h0000);
        v0 = vcount;
        for (int i = 1; i <= 40; i++) begin
            edges(1);
            if (i % 4 == 0) chk("idle_krow", 32'(krow), 32'(seq[(i / 4) % 4]));
        end
        chk("idle_no_valid", 32'(vcount - v0), 32'd0);

        // Press row2/col1
        do_reset(16'h0000);
        v0 = vcount;
        keys = 16'h0200;
        edges(60);
        chk("r2c1_pulses", 32'(vcount - v0), 32'd1);
        chk("r2c1_code",   32'(key_code),    32'd9);
        chk("r2c1_down",   32'(key_down),    32'd1);
        keys = 16'h0000;
        n = 0;
        while (key_down === 1'b1 && n < 80) begin edges(1); n++; end
        chk("r2c1_release_seen", 32'(key_down), 32'd0);
        chk("r2c1_resume_row3",  32'(krow),     32'b0111);
        edges(5);

        // Press bounce on row0/col2
        do_reset(16'h0000);
        v0 = vcount;
        for (int i = 0; i < 3; i++) begin
            keys = 16'h0004; edges(5);
            keys = 16'h0000; edges(1);
        end
        edges(40);
        chk("bounce_no_valid", 32'(vcount - v0), 32'd0);
        chk("bounce_code",     32'(key_code),    32'd0);

        // Two keys in row1: col0 wins
        do_reset(16'h0000);
        v0 = vcount;
        keys = 16'h0090;
        edges(60);
        keys = 16'h0000;
        edges(50);
        chk("two_keys_pulses", 32'(vcount - v0), 32'd1);
        chk("two_keys_code",   32'(key_code),    32'd4);
        chk("two_keys_down",   32'(key_down),    32'd0);

        // Release bounce on row3/col3
        do_reset(16'h0000);
        v0 = vcount;
        keys = 16'h8000;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 150) begin edges(1); n++; if (key_valid === 1'b1) seen = 1'b1; end
        chk("r3c3_accept_seen", 32'(seen),     32'd1);
        chk("r3c3_code",        32'(key_code), 32'd15);
        keys = 16'h0000; edges(3);
        keys = 16'h8000; edges(2);
        keys = 16'h0000;
        n = 0;
        while (key_down === 1'b1 && n < 60) begin edges(1); n++; end
        chk("r3c3_down_fall_cycles", 32'(n),            32'd22);
        chk("r3c3_single_pulse",     32'(vcount - v0),  32'd1);
        edges(5);

        // Reset mid-debounce (count 10) with row0/col0 held
        do_reset(16'h0001);
        v0 = vcount;
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_krow",  32'(krow),      32'b1110);
        chk("midrst_code",  32'(key_code),  32'd0);
        chk("midrst_valid", 32'(key_valid), 32'd0);
        chk("midrst_down",  32'(key_down),  32'd0);
        keys = 16'h0000;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        edges(1);
        chk("midrst_restart_krow", 32'(krow),         32'b1110);
        edges(30);
        chk("midrst_no_valid",     32'(vcount - v0),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
